// File: rtl/dtc_vote_accum_if.sv
// Handshake bundle for the decision-tree vote accumulator.
// Input side: codeword stream with in_flush. Output side: the held vote.
// Optional feature macro: DTC_VOTE_NSAMP_EN adds out_nsamp, the sample count behind out_vote.
interface dtc_vote_accum_if #(
    parameter int W   = 10,
    parameter int WIN = 8
);
    localparam int CW = $clog2(WIN + 1);

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_code;
    logic         in_flush;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_vote;
`ifdef DTC_VOTE_NSAMP_EN
    logic [CW-1:0] out_nsamp;

    modport master (
        output in_valid, in_code, in_flush, out_ready,
        input  in_ready, out_valid, out_vote, out_nsamp
    );
    modport slave (
        input  in_valid, in_code, in_flush, out_ready,
        output in_ready, out_valid, out_vote, out_nsamp
    );
`else
    modport master (
        output in_valid, in_code, in_flush, out_ready,
        input  in_ready, out_valid, out_vote
    );
    modport slave (
        input  in_valid, in_code, in_flush, out_ready,
        output in_ready, out_valid, out_vote
    );
`endif
endinterface

// File: rtl/dtc_vote_accum.sv
// Per-bit majority vote over windows of WIN classifier codewords (or fewer on flush).
// Optional feature macro: DTC_VOTE_NSAMP_EN adds a registered out_nsamp output.
//
// state | meaning
// ACCUM | accepting samples, counting set bits per codeword bit
// HOLD  | vote presented on out_vote, waiting for out_ready
module dtc_vote_accum #(
    parameter int W   = 10,
    parameter int WIN = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    dtc_vote_accum_if.slave  bus
);
    localparam int CW = $clog2(WIN + 1);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt [W];
    logic [CW-1:0] n;
    logic          out_valid_r;
    logic [W-1:0]  out_vote_r;

    logic          accept;
    logic          close;
    logic [CW-1:0] cnt_nx [W];
    logic [CW-1:0] n_nx;
    logic [W-1:0]  vote_nx;

    assign bus.in_ready  = (state == ACCUM);
    assign bus.out_valid = out_valid_r;
    assign bus.out_vote  = out_vote_r;
    assign accept        = bus.in_valid && (state == ACCUM);

    // Counts including this cycle's sample, and the vote they would produce.
    // The doubled count is compared one bit wider so a tie never wins.
    always_comb begin
        n_nx = n + CW'(accept);
        for (int i = 0; i < W; i++) begin
            cnt_nx[i]  = cnt[i] + CW'(accept && bus.in_code[i]);
            vote_nx[i] = ({cnt_nx[i], 1'b0} > {1'b0, n_nx});
        end
        close = (state == ACCUM) &&
                ((accept && (n == CW'(WIN - 1))) ||
                 (bus.in_flush && ((n != '0) || accept)));
    end

`ifdef DTC_VOTE_NSAMP_EN
    logic [CW-1:0] out_nsamp_r;
    assign bus.out_nsamp = out_nsamp_r;

    // Sample count captured alongside the vote.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_nsamp_r <= '0;
        end else if (close) begin
            out_nsamp_r <= n_nx;
        end
    end
`endif

    // Window FSM: accumulate, close into a registered vote, hold until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ACCUM;
            n           <= '0;
            out_valid_r <= 1'b0;
            out_vote_r  <= '0;
            for (int i = 0; i < W; i++) cnt[i] <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (close) begin
                        out_vote_r  <= vote_nx;
                        out_valid_r <= 1'b1;
                        n           <= '0;
                        for (int i = 0; i < W; i++) cnt[i] <= '0;
                        state       <= HOLD;
                    end else begin
                        n <= n_nx;
                        for (int i = 0; i < W; i++) cnt[i] <= cnt_nx[i];
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        state       <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end
endmodule

// File: tb/tb_dtc_vote_accum.sv
// Scoreboard bench for dtc_vote_accum: directed windows from the spec plus random traffic.
// Optional feature macro: DTC_VOTE_NSAMP_EN also checks out_nsamp.
module tb_dtc_vote_accum;
    localparam int W   = 10;
    localparam int WIN = 8;
`ifdef DTC_VOTE_NSAMP_EN
    localparam int CW  = $clog2(WIN + 1);
`endif

    typedef struct {
        logic [W-1:0] vote;
        int           nsamp;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dtc_vote_accum_if #(.W(W), .WIN(WIN)) bus ();
    dtc_vote_accum #(.W(W), .WIN(WIN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int           checks   = 0;
    int           failures = 0;
    logic [W-1:0] win_q[$];
    exp_t         sb[$];
    bit           busy     = 1'b0;
    bit           holding  = 1'b0;
    logic [W-1:0] held_vote;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Majority per bit over the samples of the window, strict (tie -> 0).
    function automatic logic [W-1:0] model_vote();
        logic [W-1:0] v;
        v = '0;
        for (int b = 0; b < W; b++) begin
            int ones;
            ones = 0;
            foreach (win_q[k]) ones += int'(win_q[k][b]);
            v[b] = (2 * ones > win_q.size());
        end
        return v;
    endfunction

    // One clock cycle of stimulus; called at posedge+1, returns at next posedge+1.
    task automatic cyc(input bit v, input logic [W-1:0] c, input bit f, input bit ordy);
        bit   nb;
        exp_t e;
        bus.in_valid  = v;
        bus.in_code   = c;
        bus.in_flush  = f;
        bus.out_ready = ordy;
        check("in_ready", 32'(bus.in_ready), 32'(!busy));
        check("out_valid_timing", 32'(bus.out_valid), 32'(busy));
        nb = busy;
        if (!busy) begin
            if (v) win_q.push_back(c);
            if (win_q.size() == WIN || (f && win_q.size() > 0)) begin
                e.vote  = model_vote();
                e.nsamp = win_q.size();
                sb.push_back(e);
                win_q.delete();
                nb = 1'b1;
            end
        end else if (ordy) begin
            nb = 1'b0;
        end
        @(posedge clk);
        #1;
        busy = nb;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        win_q.delete();
        sb.delete();
        busy = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_flush  = 1'b0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_vote", 32'(bus.out_vote), 32'd0);
`ifdef DTC_VOTE_NSAMP_EN
        check("rst_out_nsamp", 32'(bus.out_nsamp), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    // Monitor: pops the expected vote on every output handshake, checks hold stability.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid) begin
                if (holding) check("vote_stable", 32'(bus.out_vote), 32'(held_vote));
                held_vote = bus.out_vote;
                holding   = 1'b1;
                if (bus.out_ready) begin
                    holding = 1'b0;
                    if (sb.size() == 0) begin
                        check("unexpected_vote", 32'(bus.out_vote), 32'hFFFF_FFFF);
                    end else begin
                        e = sb.pop_front();
                        check("out_vote", 32'(bus.out_vote), 32'(e.vote));
`ifdef DTC_VOTE_NSAMP_EN
                        check("out_nsamp", 32'(bus.out_nsamp), 32'(CW'(e.nsamp)));
`endif
                    end
                end
            end else begin
                holding = 1'b0;
            end
        end
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_code   = '0;
        bus.in_flush  = 1'b0;
        bus.out_ready = 1'b0;
        #12;
        do_reset();

        // Full window of one code, then the taking cycle.
        for (int i = 0; i < 8; i++) cyc(1'b1, 10'b1000010111, 1'b0, 1'b1);
        cyc(1'b1, 10'b1000010111, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b1);

        // Tie on bit0, then 5/3 split.
        for (int i = 0; i < 4; i++) cyc(1'b1, 10'b0000000001, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b1, 10'b0000000000, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b1, 10'b0000000001, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b1, 10'b0000000000, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b1);

        // Short window closed by a lone flush.
        cyc(1'b1, 10'b0000000011, 1'b0, 1'b1);
        cyc(1'b1, 10'b0000000001, 1'b0, 1'b1);
        cyc(1'b1, 10'b0000000000, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b1, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b1);

        // Backpressure in HOLD with in_valid held high.
        for (int i = 0; i < 8; i++) cyc(1'b1, W'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b1, W'($urandom), 1'b1, 1'b0);
        cyc(1'b1, W'($urandom), 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b1, W'($urandom), 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b1, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b1);

        // Flush with empty window, then flush with the first accept.
        cyc(1'b0, '0, 1'b1, 1'b1);
        cyc(1'b0, '0, 1'b1, 1'b1);
        cyc(1'b1, 10'b1111111111, 1'b1, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b1);

        // Reset mid-window, then a clean window.
        for (int i = 0; i < 5; i++) cyc(1'b1, 10'b1111111111, 1'b0, 1'b1);
        do_reset();
        for (int i = 0; i < 8; i++) cyc(1'b1, (i < 3) ? 10'b1111111111 : 10'b0, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b1);

        // Reset while holding a vote.
        for (int i = 0; i < 8; i++) cyc(1'b1, W'($urandom), 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        do_reset();

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            cyc(($urandom_range(0, 9) < 7), W'($urandom), ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 9) < 6));
        end

        // Drain any pending vote within a bounded number of cycles.
        for (int i = 0; i < 20 && busy; i++) cyc(1'b0, '0, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b1);
        @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
